inference_sequencer: RTL
========================

# inference_sequencer

Controller that sequences one inference pass through the shared matrix-multiply engine and the argmax unit. It holds a small layer-descriptor table, issues one start/done transaction per layer, ping-pongs the activation buffers, runs argmax over the last layer's outputs, and latches the digit for the HEX display. It sits inside `neural_network`, between the UART image loader (`img_ready`) and the MM/argmax datapath. It also drives `current_state` for the LEDs.

## Interface
Parameters:
- `NUM_LAYERS`, 3: layers per pass, legal range 1..4.
- `DIM_W`, 10: width of the layer input/output dimension fields.
- `ADDR_W`, 16: width of the weight base address.
- `TIMEOUT_CYC`, 1000000: watchdog limit, in cycles, for one engine transaction.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level input (debounced key); only its rising edge is used.
- `img_ready` in 1: image buffer is full and valid.
- `cfg_we` in 1: write strobe for the descriptor table.
- `cfg_layer` in 2: descriptor index to write.
- `cfg_in_dim` in DIM_W: layer input length.
- `cfg_out_dim` in DIM_W: layer output length.
- `cfg_w_base` in ADDR_W: layer weight base address.
- `cfg_relu` in 1: apply ReLU to this layer's outputs.
- `mm_start` out 1: one-cycle start pulse to the MM engine.
- `mm_in_dim` out DIM_W, `mm_out_dim` out DIM_W, `mm_w_base` out ADDR_W, `mm_relu` out 1: current layer's descriptor.
- `mm_src_sel` out 1: activation buffer the engine reads; the engine writes the other buffer.
- `mm_done` in 1: one-cycle completion pulse from the MM engine.
- `am_start` out 1: one-cycle start pulse to the argmax unit.
- `am_len` out DIM_W: number of elements to scan.
- `am_src_sel` out 1: buffer the argmax unit reads.
- `am_done` in 1: argmax completion pulse.
- `am_result` in 4: argmax index.
- `busy` out 1: high in any state except IDLE, DONE and ERROR.
- `done` out 1: level; result is valid.
- `result` out 4: latched digit.
- `error` out 1: level; watchdog expiry or bad descriptor.
- `layer_idx` out 2: layer currently being processed.
- `current_state` out 4: state encoding below.

## Operation
- States and encodings: IDLE=0, WAIT_IMG=1, ISSUE=2, RUN=3, NEXT=4, AM_ISSUE=5, AM_RUN=6, DONE=7, ERROR=8.
- Start edge detect: `start_q` is `start` registered. An edge is seen when `start`=1 and `start_q`=0.
- The edge is honoured only in IDLE, DONE and ERROR. Honouring it:
  - clears `done`, `error` and `layer_idx`;
  - sets `mm_src_sel` to 0;
  - moves to WAIT_IMG.
- Start edges in any other state are ignored.
- WAIT_IMG: stays until `img_ready`=1, then goes to ISSUE.
- ISSUE:
  - Drives the `mm_*` descriptor from table[`layer_idx`].
  - If `in_dim`=0 or `out_dim`=0: goes to ERROR and issues no pulse.
  - Otherwise: `mm_start`=1 for this cycle only, then goes to RUN.
- RUN: the descriptor is held stable. `mm_done` is sampled only in this state; when seen, goes to NEXT.
- NEXT:
  - If `layer_idx`=NUM_LAYERS-1: goes to AM_ISSUE.
  - Otherwise: increments `layer_idx`, toggles `mm_src_sel`, goes to ISSUE.
- AM_ISSUE:
  - `am_len` = last layer's `out_dim`.
  - `am_src_sel` = ~`mm_src_sel`, i.e. the buffer the last layer wrote.
  - `am_start`=1 for one cycle, then goes to AM_RUN.
- AM_RUN: on `am_done`, latches `am_result` into `result`, sets `done`=1, goes to DONE.
- DONE: `done` and `result` hold until the next honoured start edge.
- ERROR: `error`=1 and `result` holds its old value until reset or the next honoured start edge.
- Watchdog:
  - The counter clears on entry to RUN and to AM_RUN, and increments each cycle in those states.
  - Reaching TIMEOUT_CYC-1 without a done goes to ERROR.
- Descriptor table:
  - Written on `cfg_we` when `busy`=0.
  - Writes while `busy`=1 are dropped.
  - Writes with `cfg_layer` ≥ NUM_LAYERS are dropped.
- Done pulses (`mm_done`, `am_done`) arriving outside their RUN state are ignored.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Reset also clears the descriptor table, `start_q` and the watchdog.
- Reset mid-pass: on the next edge the block is in IDLE with `mm_start`/`am_start` low, regardless of engine activity.
- Latency:
  - Edge at cycle t gives WAIT_IMG at t+1. With `img_ready` high, `mm_start` is high during t+2.
  - `mm_done` in cycle d (state RUN) gives NEXT at d+1 and the next `mm_start` at d+2.
  - `am_done` in cycle a gives `done`=1 and `result` valid at a+1.
- `mm_start`/`am_start` are never high for two consecutive cycles and never high outside ISSUE/AM_ISSUE.
- A `cfg_we` in the same cycle as an honoured start edge is accepted; a pass uses the table as it stands at ISSUE.

## Test plan
- 3-layer pass:
  - Stimulus: table {784→32 relu base 0, 32→16 relu base 25088, 16→10 base 25600}; `img_ready`=1; MM model answers `mm_done` 5 cycles after each start; `am_result`=7.
  - Response: three `mm_start` pulses carrying those descriptors, `mm_src_sel` 0,1,0, `am_len`=10, `am_src_sel`=1, `done`=1, `result`=7, `current_state`=7.
- Start while busy: a second start edge during RUN produces no state change, no extra `mm_start`, and `layer_idx` is not reset.
- Watchdog: TIMEOUT_CYC=100 and `mm_done` withheld give ERROR after exactly 100 RUN cycles, with `error`=1 and `busy`=0. A new start edge then clears `error`.
- Bad descriptor: layer 1 `out_dim`=0 sends the block to ERROR from ISSUE with only one `mm_start` total.
- Reset during AM_RUN: `reset` for 1 cycle gives all outputs 0 and IDLE. A late `am_done` is ignored and `result` stays 0.
- Config while busy: `cfg_we` during RUN leaves the table unchanged, checked on the next pass's `mm_*` outputs.

Source files
------------

// File: rtl/inference_sequencer.sv
// inference_sequencer: walks one inference pass through the shared MM engine
// (one start/done transaction per layer, ping-ponging activation buffers), then
// runs argmax over the last layer's outputs and latches the resulting digit.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, img_ready      pass request (rising edge) and image-buffer-valid
//   cfg_*                 descriptor table write port (accepted only when idle)
//   mm_*                  MM engine start pulse, descriptor, buffer select, done
//   am_*                  argmax start pulse, length, buffer select, done, index
//   busy, done, error     status levels
//   result, layer_idx     latched digit, layer in progress
//   current_state         state encoding for the LEDs
module inference_sequencer #(
    parameter int unsigned NUM_LAYERS  = 3,
    parameter int unsigned DIM_W       = 10,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              img_ready,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_layer,
    input  logic [DIM_W-1:0]  cfg_in_dim,
    input  logic [DIM_W-1:0]  cfg_out_dim,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic              cfg_relu,
    output logic              mm_start,
    output logic [DIM_W-1:0]  mm_in_dim,
    output logic [DIM_W-1:0]  mm_out_dim,
    output logic [ADDR_W-1:0] mm_w_base,
    output logic              mm_relu,
    output logic              mm_src_sel,
    input  logic              mm_done,
    output logic              am_start,
    output logic [DIM_W-1:0]  am_len,
    output logic              am_src_sel,
    input  logic              am_done,
    input  logic [3:0]        am_result,
    output logic              busy,
    output logic              done,
    output logic [3:0]        result,
    output logic              error,
    output logic [1:0]        layer_idx,
    output logic [3:0]        current_state
);

    localparam int unsigned     WD_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]      LAST_LAYER = 2'(NUM_LAYERS - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WAIT_IMG = 4'd1,
        ISSUE    = 4'd2,
        RUN      = 4'd3,
        NEXT     = 4'd4,
        AM_ISSUE = 4'd5,
        AM_RUN   = 4'd6,
        DONE     = 4'd7,
        ERROR    = 4'd8
    } state_t;

    typedef struct packed {
        logic [DIM_W-1:0]  in_dim;
        logic [DIM_W-1:0]  out_dim;
        logic [ADDR_W-1:0] w_base;
        logic              relu;
    } desc_t;

    state_t            state_q, state_d;
    desc_t             tbl_q [4];
    logic              start_q;
    logic [WD_W-1:0]   wd_q;

    logic              mm_start_q, mm_relu_q, mm_src_sel_q;
    logic [DIM_W-1:0]  mm_in_dim_q, mm_out_dim_q, am_len_q;
    logic [ADDR_W-1:0] mm_w_base_q;
    logic              am_start_q, am_src_sel_q;
    logic              busy_q, done_q, error_q;
    logic [3:0]        result_q;
    logic [1:0]        layer_idx_q;

    logic              start_edge, honour_start, wd_expired, cfg_ok, issue_ok;
    logic [1:0]        issue_idx;
    desc_t             issue_desc;

    assign start_edge   = start & ~start_q;
    assign honour_start = start_edge && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign wd_expired   = (wd_q == WD_LAST);
    assign cfg_ok       = cfg_we && !busy_q && (32'(cfg_layer) < NUM_LAYERS);

    // Descriptor for the ISSUE state being entered (from NEXT the index is about to advance).
    assign issue_idx  = (state_q == NEXT) ? layer_idx_q + 2'd1 : layer_idx_q;
    assign issue_desc = tbl_q[issue_idx];
    assign issue_ok   = (|issue_desc.in_dim) && (|issue_desc.out_dim);

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (start_edge) state_d = WAIT_IMG;
            WAIT_IMG:          if (img_ready) state_d = ISSUE;
            ISSUE:             state_d = issue_ok ? RUN : ERROR;
            RUN: begin
                if (mm_done)         state_d = NEXT;
                else if (wd_expired) state_d = ERROR;
            end
            NEXT:              state_d = (layer_idx_q == LAST_LAYER) ? AM_ISSUE : ISSUE;
            AM_ISSUE:          state_d = AM_RUN;
            AM_RUN: begin
                if (am_done)         state_d = DONE;
                else if (wd_expired) state_d = ERROR;
            end
            default:           state_d = IDLE;
        endcase
    end

    // State, table and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            wd_q         <= '0;
            for (int i = 0; i < 4; i++) tbl_q[i] <= '0;
            mm_start_q   <= 1'b0;
            mm_in_dim_q  <= '0;
            mm_out_dim_q <= '0;
            mm_w_base_q  <= '0;
            mm_relu_q    <= 1'b0;
            mm_src_sel_q <= 1'b0;
            am_start_q   <= 1'b0;
            am_len_q     <= '0;
            am_src_sel_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            result_q     <= '0;
            layer_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            busy_q     <= !(state_d == IDLE || state_d == DONE || state_d == ERROR);
            // Pulses are set only on entry to their issue state, so they last one cycle.
            mm_start_q <= (state_d == ISSUE) && issue_ok;
            am_start_q <= (state_d == AM_ISSUE);

            if (cfg_ok) tbl_q[cfg_layer] <= {cfg_in_dim, cfg_out_dim, cfg_w_base, cfg_relu};

            if (honour_start) begin
                done_q       <= 1'b0;
                error_q      <= 1'b0;
                layer_idx_q  <= '0;
                mm_src_sel_q <= 1'b0;
            end

            if (state_q == NEXT && state_d == ISSUE) begin
                layer_idx_q  <= layer_idx_q + 2'd1;
                mm_src_sel_q <= ~mm_src_sel_q;
            end

            if (state_d == ISSUE) begin
                mm_in_dim_q  <= issue_desc.in_dim;
                mm_out_dim_q <= issue_desc.out_dim;
                mm_w_base_q  <= issue_desc.w_base;
                mm_relu_q    <= issue_desc.relu;
            end

            // Argmax reads the buffer the last layer wrote.
            if (state_d == AM_ISSUE) begin
                am_len_q     <= tbl_q[LAST_LAYER].out_dim;
                am_src_sel_q <= ~mm_src_sel_q;
            end

            if (state_q == AM_RUN && am_done) begin
                result_q <= am_result;
                done_q   <= 1'b1;
            end

            if (state_d == ERROR) error_q <= 1'b1;

            // Watchdog restarts on entry to each wait state.
            if ((state_d == RUN || state_d == AM_RUN) && state_d != state_q)
                wd_q <= '0;
            else if (state_q == RUN || state_q == AM_RUN)
                wd_q <= wd_q + WD_W'(1);
        end
    end

    assign mm_start      = mm_start_q;
    assign mm_in_dim     = mm_in_dim_q;
    assign mm_out_dim    = mm_out_dim_q;
    assign mm_w_base     = mm_w_base_q;
    assign mm_relu       = mm_relu_q;
    assign mm_src_sel    = mm_src_sel_q;
    assign am_start      = am_start_q;
    assign am_len        = am_len_q;
    assign am_src_sel    = am_src_sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign error         = error_q;
    assign layer_idx     = layer_idx_q;
    assign current_state = state_q;

endmodule
